// File: rtl/dmem_mmio_responder.sv
// Data-bus responder: word RAM plus a 4-register MMIO window (tohost, cycle, scratch, status).
// Reads are combinational with zero latency; writes commit on the clk edge; the bus never stalls.
module dmem_mmio_responder #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] MMIO_BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic [1:0]  result,
  output logic        done,
  output logic        bus_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd8;

  typedef enum logic {RUN, HALT} state_t;

  logic [63:0] mem [DEPTH];
  logic [31:0] ram_off;
  logic [31:0] mmio_off;
  logic        ram_hit;
  logic        mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [1:0]  reg_sel;
  logic        tohost_wr;
  logic        miss_access;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] tohost_q;
  logic [63:0] cycle_q;
  logic [63:0] scratch_q;
  logic [1:0]  result_q;
  logic        bus_err_q;

  // Subtraction plus full-width compare keeps the decode exact for any base alignment.
  assign ram_off  = addr - RAM_BASE;
  assign mmio_off = addr - MMIO_BASE;
  assign ram_hit  = (addr >= RAM_BASE) && ({1'b0, ram_off} < RAM_BYTES);
  assign mmio_hit = (addr >= MMIO_BASE) && (mmio_off < 32'd32);
  assign ram_idx  = ram_off[AW+2:3];
  assign reg_sel  = addr[4:3];

  assign tohost_wr   = we && mmio_hit && (reg_sel == 2'd0) && (state_q == RUN) &&
                       (write_data != 64'd0);
  // core has no read strobe, so an idle bus (we=0, addr=0) is not an access.
  assign miss_access = !ram_hit && !mmio_hit && (we || (addr != 32'd0));

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN && tohost_wr) state_d = HALT;
  end

  always_comb begin
    done = (state_q == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tohost_q  <= 64'd0;
      cycle_q   <= 64'd0;
      scratch_q <= 64'd0;
      result_q  <= 2'b00;
      bus_err_q <= 1'b0;
    end else begin
      if (state_q == RUN && !tohost_wr) cycle_q <= cycle_q + 64'd1;
      if (tohost_wr) begin
        tohost_q <= write_data;
        result_q <= (write_data == 64'd1) ? 2'b10 : 2'b01;
      end
      if (we && mmio_hit && reg_sel == 2'd2) scratch_q <= write_data;
      if (miss_access) bus_err_q <= 1'b1;
    end
  end

  // RAM is not reset; reset only suppresses a coincident write.
  always_ff @(posedge clk) begin
    if (we && ram_hit && !reset) mem[ram_idx] <= write_data;
  end

  always_comb begin
    read_data = 64'd0;
    if (ram_hit) begin
      read_data = mem[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        2'd0:    read_data = tohost_q;
        2'd1:    read_data = cycle_q;
        2'd2:    read_data = scratch_q;
        default: read_data = {60'd0, bus_err_q, result_q, done};
      endcase
    end
  end

  assign result  = result_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench: stimulus pushes predicted outputs from a behavioural model; a negedge monitor compares.
module tb_dmem_mmio_responder;

  localparam int          DEPTH     = 4096;
  localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
  localparam logic [31:0] MMIO_BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        we = 1'b0;
  logic [63:0] write_data = 64'd0;
  logic [63:0] read_data;
  logic [1:0]  result;
  logic        done;
  logic        bus_err;

  dmem_mmio_responder #(.DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .write_data(write_data),
    .read_data(read_data), .result(result), .done(done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rd;
    bit          rd_known;
    logic [1:0]  res;
    bit          dn;
    bit          be;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;

  // Reference model state: test outcome, registers, and only the RAM words the bench has written.
  logic [63:0] mem_m [int];
  logic [1:0]  m_result;
  logic [63:0] m_tohost, m_cycle, m_scratch;
  bit          m_berr;
  bit          model_ok = 0;

  function automatic bit in_ram(logic [31:0] a);
    return (longint'(a) >= longint'(RAM_BASE)) &&
           (longint'(a) - longint'(RAM_BASE) < longint'(DEPTH) * 8);
  endfunction

  function automatic bit in_mmio(logic [31:0] a);
    return (longint'(a) >= longint'(MMIO_BASE)) && (longint'(a) - longint'(MMIO_BASE) < 32);
  endfunction

  function automatic int ram_word(logic [31:0] a);
    return int'((longint'(a) - longint'(RAM_BASE)) / 8);
  endfunction

  function automatic int mmio_reg(logic [31:0] a);
    return int'((longint'(a) - longint'(MMIO_BASE)) / 8);
  endfunction

  function automatic exp_t predict(logic [31:0] a);
    exp_t e;
    e.rd = 64'd0;
    e.rd_known = 1;
    e.res = m_result;
    e.dn = (m_result != 2'b00);
    e.be = m_berr;
    e.tag = tag;
    if (in_ram(a)) begin
      if (mem_m.exists(ram_word(a))) e.rd = mem_m[ram_word(a)];
      else e.rd_known = 0;
    end else if (in_mmio(a)) begin
      case (mmio_reg(a))
        0: e.rd = m_tohost;
        1: e.rd = m_cycle;
        2: e.rd = m_scratch;
        default: e.rd = 64'(m_berr) * 8 + 64'(m_result) * 2 + 64'(m_result != 2'b00);
      endcase
    end
    return e;
  endfunction

  task automatic model_edge(bit rst, logic [31:0] a, bit w, logic [63:0] d);
    bit accept;
    if (rst) begin
      m_result = 2'b00; m_tohost = 0; m_cycle = 0; m_scratch = 0; m_berr = 0;
      return;
    end
    accept = w && in_mmio(a) && mmio_reg(a) == 0 && m_result == 2'b00 && d != 0;
    if (m_result == 2'b00 && !accept) m_cycle = m_cycle + 1;
    if (w && in_ram(a)) mem_m[ram_word(a)] = d;
    if (w && in_mmio(a) && mmio_reg(a) == 2) m_scratch = d;
    if (accept) begin
      m_tohost = d;
      m_result = (d == 64'd1) ? 2'b10 : 2'b01;
    end
    if (!in_ram(a) && !in_mmio(a) && (w || a != 0)) m_berr = 1;
  endtask

  task automatic cyc(bit rst, logic [31:0] a, bit w, logic [63:0] d);
    @(posedge clk);
    #1;
    reset = rst; addr = a; we = w; write_data = d;
    tag++;
    if (model_ok) exp_q.push_back(predict(a));
    model_edge(rst, a, w, d);
    if (rst) model_ok = 1;
  endtask

  task automatic idle();
    cyc(0, 32'd0, 0, 64'd0);
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want, int t);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle_tag=%0d got=%h want=%h", nm, t, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.rd_known) chk("read_data", read_data, e.rd, e.tag);
      chk("result", 64'(result), 64'(e.res), e.tag);
      chk("done", 64'(done), 64'(e.dn), e.tag);
      chk("bus_err", 64'(bus_err), 64'(e.be), e.tag);
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 10))
      0, 1, 2: return RAM_BASE + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(0, 7));
      3:       return RAM_BASE + 32'((DEPTH - 1) * 8);
      4:       return RAM_BASE + 32'(DEPTH * 8);
      5, 6:    return MMIO_BASE + 32'($urandom_range(0, 31));
      7:       return MMIO_BASE + 32'd32;
      8:       return RAM_BASE - 32'd8;
      9:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Bring-up: idle bus after reset, cycle counter reads 10.
    cyc(1, 0, 0, 0);
    repeat (10) idle();
    cyc(0, MMIO_BASE + 8, 0, 0);
    cyc(0, MMIO_BASE + 24, 0, 0);

    // Read-during-write returns the old word.
    cyc(0, RAM_BASE + 8, 1, 64'h1111_2222_3333_4444);
    cyc(0, RAM_BASE + 16, 1, 64'h5555_6666_7777_8888);
    cyc(0, RAM_BASE + 16, 1, 64'hDEAD_BEEF_0123_4567);
    cyc(0, RAM_BASE + 16, 0, 0);
    cyc(0, RAM_BASE + 8, 0, 0);

    // Pass at cycle 20, counter frozen, later tohost writes ignored.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 40 && m_cycle != 20; k++) idle();
    cyc(0, MMIO_BASE, 1, 64'd1);
    cyc(0, MMIO_BASE + 8, 0, 0);
    repeat (3) idle();
    cyc(0, MMIO_BASE + 8, 0, 0);
    cyc(0, MMIO_BASE, 1, 64'd7);
    cyc(0, MMIO_BASE, 0, 0);
    cyc(0, MMIO_BASE + 24, 0, 0);

    // Fail with test number, then reset restarts everything.
    cyc(1, 0, 0, 0);
    cyc(0, MMIO_BASE, 1, 64'd0);
    cyc(0, MMIO_BASE, 1, 64'd7);
    cyc(0, MMIO_BASE, 0, 0);
    cyc(0, MMIO_BASE + 24, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, MMIO_BASE + 8, 0, 0);
    cyc(0, MMIO_BASE + 8, 0, 0);

    // Out-of-window write sets a sticky bus error and touches nothing.
    cyc(0, 32'h1000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(0, 32'h1000_0000, 0, 0);
    cyc(0, RAM_BASE + 16, 0, 0);
    cyc(0, MMIO_BASE + 16, 0, 0);
    repeat (2) idle();

    // Scratch write, ignored cycle write, reset beats a RAM write.
    cyc(1, 0, 0, 0);
    cyc(0, MMIO_BASE + 16, 1, 64'd5);
    cyc(0, MMIO_BASE + 8, 1, 64'hABCD);
    cyc(0, MMIO_BASE + 16, 0, 0);
    cyc(0, MMIO_BASE + 8, 0, 0);
    cyc(1, RAM_BASE + 16, 1, 64'h0BAD_0BAD_0BAD_0BAD);
    cyc(0, RAM_BASE + 16, 0, 0);
    cyc(0, MMIO_BASE + 24, 0, 0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] d;
      if ($urandom_range(0, 3) == 0) d = 64'($urandom_range(0, 2));
      else d = {$urandom, $urandom};
      cyc($urandom_range(0, 40) == 0, rand_addr(), $urandom_range(0, 1) == 1, d);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
